ux607_pwm_icb: RTL and testbench
================================

UX607_PWM_ICB -- requirements
Module: ux607_pwm_icb

Interface
- REQ-001 Parameter NCH, default 4: number of compare channels (1..8).
- REQ-002 Parameter CMPW, default 16: compare/scaled-count width (8..16).
- REQ-003 Parameter CNTW, default CMPW+15: raw counter width.
- REQ-004 clk  in  1  sole clock; rst_n  in  1  reset, asynchronous, active-low.
- REQ-005 i_icb_cmd_valid/ready  in/out  1/1  command handshake; i_icb_cmd_addr  in  `UX607_PA_SIZE  byte address (only [7:2] decoded); i_icb_cmd_read  in  1  1=read; i_icb_cmd_wdata  in  32  write data.
- REQ-006 i_icb_rsp_valid  out  1  response valid; i_icb_rsp_ready  in  1  response accept; i_icb_rsp_rdata  out  32  read data (0 for writes).
- REQ-007 io_interrupts  out  NCH  per-channel pending interrupt; io_gpio  out  NCH  per-channel PWM output.

Function
- REQ-008 Register map: 0x00 CFG; 0x08 COUNT (rw, CNTW bits); 0x10 PWMS (ro, scaled count); 0x20+4*i CMPi (rw, CMPW bits, i<NCH); unmapped reads return 0, unmapped writes ignored.
- REQ-009 CFG fields: [3:0] scale, [8] sticky, [9] zerocmp, [12] enalways, [13] enoneshot, [14] center, [16+i] ip[i] (rw, i<NCH); unused bits read 0.
- REQ-010 One outstanding transaction: cmd_ready = ~rsp_valid | rsp_ready; a command accepted in cycle N produces rsp_valid in N+1, held until rsp_ready.
- REQ-011 Register writes take effect in the cycle after acceptance; reads return the value at acceptance.
- REQ-012 COUNT increments by 1 per cycle while enalways or enoneshot is set; wraps to 0 at 2^CNTW-1.
- REQ-013 PWMS = COUNT[scale +: CMPW], zero-extended when scale+CMPW exceeds CNTW.
- REQ-014 Compare hit[i] = (PWMS >= CMPi), combinational on current registers.
- REQ-015 zerocmp=1 and hit[0]: COUNT loads 0 next cycle instead of incrementing, and enoneshot clears.
- REQ-016 ip[i] next = hit[i] | (sticky & ip[i]); a CFG write to ip bits overrides hardware update in that cycle.
- REQ-017 io_gpio[i] = ip[i]; io_interrupts[i] = ip[i]; both registered.
- REQ-018 SW write to COUNT in the same cycle as an increment or zerocmp reload: SW value wins.
- REQ-019 CMPi = 0 with counter enabled: hit[i] permanently 1.

Reset
- REQ-020 On rst_n low: CFG, COUNT, all CMPi, ip, direction flag cleared to 0; rsp_valid=0, rsp_rdata=0, io_gpio=0, io_interrupts=0.
- REQ-021 Reset mid-transaction discards the pending response; cmd_ready=1 in the first cycle after rst_n release.

Configuration
- REQ-022 Macro UX607_PWM_CENTER_ALIGN_EN: when defined, CFG[14] is writable and, with zerocmp=1, COUNT counts up until hit[0], then decrements one per cycle to 0, then counts up again (no reload); enoneshot clears on return to 0.
- REQ-023 Without UX607_PWM_CENTER_ALIGN_EN: CFG[14] reads 0, writes ignored, direction logic absent, edge-aligned behaviour only.

Verification
- REQ-024 Write CMP0=0x0010, CFG=0x1200 (enalways, zerocmp, scale 0) -> COUNT cycles 0..0x10, ip[0]/io_gpio[0] high one cycle per period of 17 cycles.
- REQ-025 CFG scale=4, CMP1=3, enalways -> PWMS increments every 16 cycles; io_gpio[1] rises when COUNT reaches 0x30.
- REQ-026 sticky=1, CMP2=5 -> ip[2] stays 1 after COUNT wraps; CFG write with bit 18=0 clears it next cycle.
- REQ-027 enoneshot only, zerocmp, CMP0=8 -> one period, COUNT returns to 0 and stops, CFG[13] reads 0.
- REQ-028 Back-to-back reads with rsp_ready held low 3 cycles -> cmd_ready low for those cycles, rdata stable, second command accepted the cycle rsp_ready rises.
- REQ-029 With UX607_PWM_CENTER_ALIGN_EN, center=1, zerocmp, CMP0=4 -> COUNT sequence 0,1,2,3,4,3,2,1,0,1...

Source files
------------

// File: rtl/ux607_pwm_icb_if.sv
// ux607_pwm_icb_if: ICB command/response channel between a bus master and the PWM block.
`ifndef UX607_PA_SIZE
`define UX607_PA_SIZE 32
`endif
interface ux607_pwm_icb_if;
  logic                      i_icb_cmd_valid;
  logic                      i_icb_cmd_ready;
  logic [`UX607_PA_SIZE-1:0] i_icb_cmd_addr;
  logic                      i_icb_cmd_read;
  logic [31:0]               i_icb_cmd_wdata;
  logic                      i_icb_rsp_valid;
  logic                      i_icb_rsp_ready;
  logic [31:0]               i_icb_rsp_rdata;
  modport master (
    output i_icb_cmd_valid, i_icb_cmd_addr, i_icb_cmd_read, i_icb_cmd_wdata, i_icb_rsp_ready,
    input  i_icb_cmd_ready, i_icb_rsp_valid, i_icb_rsp_rdata
  );
  modport slave (
    input  i_icb_cmd_valid, i_icb_cmd_addr, i_icb_cmd_read, i_icb_cmd_wdata, i_icb_rsp_ready,
    output i_icb_cmd_ready, i_icb_rsp_valid, i_icb_rsp_rdata
  );
endinterface

// File: rtl/ux607_pwm_icb.sv
// ux607_pwm_icb: ICB-mapped PWM timer with NCH compare channels.
// Defining UX607_PWM_CENTER_ALIGN_EN adds up/down (center-aligned) counting via CFG[14].
`ifndef UX607_PA_SIZE
`define UX607_PA_SIZE 32
`endif
module ux607_pwm_icb #(
  parameter int NCH  = 4,
  parameter int CMPW = 16,
  parameter int CNTW = CMPW + 15
) (
  input  logic           clk,
  input  logic           rst_n,
  ux607_pwm_icb_if.slave bus,
  output logic [NCH-1:0] io_interrupts,
  output logic [NCH-1:0] io_gpio
);
  logic [3:0]      scale;
  logic            sticky, zerocmp, enalways, enoneshot, center, en, oneshot_clr;
  logic [NCH-1:0]  ip, hit, ip_nxt;
  logic [CNTW-1:0] count, count_nxt;
  logic [CMPW-1:0] pwms;
  logic [CMPW-1:0] cmp [NCH];
  logic            accept, wr, cfg_wr, count_wr;
  logic [5:0]      a;
  logic [31:0]     cfg_rd, rdata;
  logic            unused_bits;

  assign bus.i_icb_cmd_ready = ~bus.i_icb_rsp_valid | bus.i_icb_rsp_ready;
  assign accept = bus.i_icb_cmd_valid & bus.i_icb_cmd_ready;
  assign a = bus.i_icb_cmd_addr[7:2];
  assign wr = accept & ~bus.i_icb_cmd_read;
  assign cfg_wr = wr & (a == 6'h00);
  assign count_wr = wr & (a == 6'h02);
  assign en = enalways | enoneshot;
  assign pwms = CMPW'(count >> scale);
  assign ip_nxt = hit | ({NCH{sticky}} & ip);
  assign io_gpio = ip;
  assign io_interrupts = ip;
  assign unused_bits = ^{bus.i_icb_cmd_addr, bus.i_icb_cmd_wdata};

  always_comb
    for (int i = 0; i < NCH; i++) hit[i] = pwms >= cmp[i];

  always_comb begin
    cfg_rd = '0;
    cfg_rd[3:0] = scale;
    cfg_rd[8] = sticky;
    cfg_rd[9] = zerocmp;
    cfg_rd[12] = enalways;
    cfg_rd[13] = enoneshot;
    cfg_rd[14] = center;
    cfg_rd[16+:NCH] = ip;
  end

  always_comb begin
    rdata = (a == 6'h00) ? cfg_rd : (a == 6'h02) ? 32'(count) : (a == 6'h04) ? 32'(pwms) : '0;
    for (int i = 0; i < NCH; i++)
      if (a == 6'(8 + i)) rdata = 32'(cmp[i]);
  end

`ifdef UX607_PWM_CENTER_ALIGN_EN
  logic dir, dir_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      center <= 1'b0;
      dir <= 1'b0;
    end else begin
      center <= cfg_wr ? bus.i_icb_cmd_wdata[14] : center;
      dir <= dir_nxt;
    end
`else
  assign center = 1'b0;
`endif

  always_comb begin
    count_nxt = (zerocmp & hit[0]) ? '0 : en ? count + CNTW'(1) : count;
    oneshot_clr = zerocmp & hit[0];
`ifdef UX607_PWM_CENTER_ALIGN_EN
    dir_nxt = 1'b0;
    // Turn down on the compare hit; reaching zero flips back up and ends a one-shot
    if (center & zerocmp & en & (dir | hit[0])) begin
      dir_nxt = count > CNTW'(1);
      count_nxt = dir_nxt ? count - CNTW'(1) : '0;
      oneshot_clr = ~dir_nxt;
    end else if (center & zerocmp) begin
      dir_nxt = dir;
      count_nxt = en ? count + CNTW'(1) : count;
      oneshot_clr = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.i_icb_rsp_valid <= 1'b0;
      bus.i_icb_rsp_rdata <= '0;
      {scale, sticky, zerocmp, enalways, enoneshot} <= '0;
      ip <= '0;
      count <= '0;
      for (int i = 0; i < NCH; i++) cmp[i] <= '0;
    end else begin
      bus.i_icb_rsp_valid <= accept | (bus.i_icb_rsp_valid & ~bus.i_icb_rsp_ready);
      if (accept) bus.i_icb_rsp_rdata <= bus.i_icb_cmd_read ? rdata : '0;
      if (cfg_wr) begin
        scale <= bus.i_icb_cmd_wdata[3:0];
        sticky <= bus.i_icb_cmd_wdata[8];
        zerocmp <= bus.i_icb_cmd_wdata[9];
        enalways <= bus.i_icb_cmd_wdata[12];
      end
      enoneshot <= cfg_wr ? bus.i_icb_cmd_wdata[13] : enoneshot & ~oneshot_clr;
      ip <= cfg_wr ? bus.i_icb_cmd_wdata[16+:NCH] : ip_nxt;
      count <= count_wr ? bus.i_icb_cmd_wdata[CNTW-1:0] : count_nxt;
      for (int i = 0; i < NCH; i++)
        if (wr & (a == 6'(8 + i))) cmp[i] <= bus.i_icb_cmd_wdata[CMPW-1:0];
    end
endmodule

// File: tb/tb_ux607_pwm_icb.sv
// tb_ux607_pwm_icb: directed self-checking bench for ux607_pwm_icb (default parameters).
module tb_ux607_pwm_icb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  gpio, irq;
  logic [31:0] rd;
  int          total = 0;
  int          bad = 0;

  ux607_pwm_icb_if bus ();
  ux607_pwm_icb dut (.clk(clk), .rst_n(rst_n), .bus(bus), .io_interrupts(irq), .io_gpio(gpio));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] adr, input logic r, input logic [31:0] d);
    @(negedge clk);
    bus.i_icb_cmd_valid = 1'b1;
    bus.i_icb_cmd_addr = '0;
    bus.i_icb_cmd_addr[7:0] = adr;
    bus.i_icb_cmd_read = r;
    bus.i_icb_cmd_wdata = d;
    bus.i_icb_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_icb_cmd_valid = 1'b0;
    rd = bus.i_icb_rsp_rdata;
  endtask

  initial begin
    bus.i_icb_cmd_valid = 1'b0;
    bus.i_icb_cmd_addr = '0;
    bus.i_icb_cmd_read = 1'b0;
    bus.i_icb_cmd_wdata = '0;
    bus.i_icb_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gpio", 32'(gpio), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_rsp_valid", 32'(bus.i_icb_rsp_valid), 0);
    rst_n = 1'b1;
    // reset while a response is pending
    @(negedge clk);
    bus.i_icb_cmd_valid = 1'b1;
    bus.i_icb_cmd_addr = 8;
    bus.i_icb_cmd_read = 1'b1;
    bus.i_icb_rsp_ready = 1'b0;
    @(negedge clk);
    bus.i_icb_cmd_valid = 1'b0;
    chk("pend_rsp_valid", 32'(bus.i_icb_rsp_valid), 1);
    chk("pend_cmd_ready", 32'(bus.i_icb_cmd_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("rst_drops_rsp", 32'(bus.i_icb_rsp_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(bus.i_icb_cmd_ready), 1);
    bus.i_icb_rsp_ready = 1'b1;
    xfer(8'h08, 1'b1, 0);
    chk("count_rst", rd, 0);
    xfer(8'h20, 1'b1, 0);
    chk("cmp0_rst", rd, 0);
    // edge-aligned period of 17 with zerocmp reload
    xfer(8'h20, 1'b0, 32'h10);
    chk("wr_rdata_zero", rd, 0);
    xfer(8'h00, 1'b0, 32'h1200);
    for (int k = 0; k < 36; k++) begin
      chk("edge_count", 32'(dut.count), 32'(k % 17));
      chk("edge_gpio0", 32'(gpio[0]), 32'((k % 17 == 0) && (k > 0)));
      if (k > 0) chk("cmp_zero_irq3", 32'(irq[3]), 1);
      @(negedge clk);
    end
    // COUNT/PWMS access while stopped
    xfer(8'h00, 1'b0, 0);
    xfer(8'h08, 1'b0, 32'h1234);
    xfer(8'h08, 1'b1, 0);
    chk("count_rw", rd, 32'h1234);
    xfer(8'h10, 1'b1, 0);
    chk("pwms_scale0", rd, 32'h1234);
    xfer(8'h00, 1'b0, 32'h0004);
    xfer(8'h10, 1'b1, 0);
    chk("pwms_scale4", rd, 32'h0123);
    // scale 4, CMP1=3
    xfer(8'h08, 1'b0, 0);
    xfer(8'h24, 1'b0, 3);
    xfer(8'h00, 1'b0, 32'h1004);
    for (int k = 0; k < 53; k++) begin
      chk("scale_pwms", 32'(dut.pwms), 32'(k >> 4));
      chk("scale_gpio1", 32'(gpio[1]), 32'(k >= 49));
      @(negedge clk);
    end
    // sticky ip[2] across counter wrap
    xfer(8'h00, 1'b0, 0);
    xfer(8'h28, 1'b0, 5);
    xfer(8'h08, 1'b0, 32'h7FFF_FFFC);
    xfer(8'h00, 1'b0, 32'h1100);
    for (int k = 0; k < 10; k++) begin
      chk("wrap_count", 32'(dut.count), (32'h7FFF_FFFC + 32'(k)) & 32'h7FFF_FFFF);
      chk("sticky_gpio2", 32'(gpio[2]), 32'(k >= 1));
      @(negedge clk);
    end
    xfer(8'h00, 1'b0, 32'h1100);
    chk("sticky_clear", 32'(gpio[2]), 0);
    @(negedge clk);
    chk("sticky_rehit", 32'(gpio[2]), 1);
    // one-shot period with zerocmp
    xfer(8'h00, 1'b0, 0);
    xfer(8'h08, 1'b0, 0);
    xfer(8'h20, 1'b0, 8);
    xfer(8'h00, 1'b0, 32'h2200);
    for (int k = 0; k < 15; k++) begin
      chk("oneshot_count", 32'(dut.count), (k <= 8) ? 32'(k) : 0);
      chk("oneshot_gpio0", 32'(gpio[0]), 32'(k == 9));
      @(negedge clk);
    end
    xfer(8'h00, 1'b1, 0);
    chk("oneshot_cfg", rd, 32'h0008_0200);
    // back-to-back reads with response stalled three cycles
    @(negedge clk);
    bus.i_icb_cmd_valid = 1'b1;
    bus.i_icb_cmd_addr = 32'h20;
    bus.i_icb_cmd_read = 1'b1;
    bus.i_icb_rsp_ready = 1'b0;
    chk("b2b_ready_idle", 32'(bus.i_icb_cmd_ready), 1);
    @(negedge clk);
    bus.i_icb_cmd_addr = 32'h28;
    for (int i = 0; i < 3; i++) begin
      chk("b2b_stall_ready", 32'(bus.i_icb_cmd_ready), 0);
      chk("b2b_stall_valid", 32'(bus.i_icb_rsp_valid), 1);
      chk("b2b_rdata_hold", bus.i_icb_rsp_rdata, 8);
      @(negedge clk);
    end
    bus.i_icb_rsp_ready = 1'b1;
    #1;
    chk("b2b_ready_rise", 32'(bus.i_icb_cmd_ready), 1);
    @(negedge clk);
    bus.i_icb_cmd_valid = 1'b0;
    chk("b2b_second_valid", 32'(bus.i_icb_rsp_valid), 1);
    chk("b2b_second_rdata", bus.i_icb_rsp_rdata, 5);
    @(negedge clk);
    chk("b2b_drain", 32'(bus.i_icb_rsp_valid), 0);
`ifdef UX607_PWM_CENTER_ALIGN_EN
    xfer(8'h00, 1'b0, 32'h4000);
    xfer(8'h00, 1'b1, 0);
    chk("center_bit", rd, 32'h0008_4000);
    xfer(8'h00, 1'b0, 0);
    xfer(8'h08, 1'b0, 0);
    xfer(8'h20, 1'b0, 4);
    xfer(8'h00, 1'b0, 32'h5200);
    for (int k = 0; k < 17; k++) begin
      chk("center_count", 32'(dut.count), ((k % 8) <= 4) ? 32'(k % 8) : 32'(8 - k % 8));
      @(negedge clk);
    end
`else
    xfer(8'h00, 1'b0, 32'h4000);
    xfer(8'h00, 1'b1, 0);
    chk("center_bit_absent", rd, 32'h0008_0000);
`endif
    xfer(8'h30, 1'b1, 0);
    chk("unmapped_read", rd, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
